// File: rtl/mult_pkg.sv
// Shared types and widths for the 8x8 sequential shift-and-add multiplier.
// Width is pinned at 8 by the ripple-carry adder; the product width follows.
package mult_pkg;

    localparam int MULT_WIDTH = 8;
    localparam int PROD_WIDTH = 16;
    localparam int ITER_LAST  = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_8_bits_structure.sv
// 8-bit ripple-carry adder with bit-scalar ports, built from per-bit sum/carry equations.
// Purely combinational: zero latency, no flow control.
module full_adder_8_bits_structure (
    input  logic a0, a1, a2, a3, a4, a5, a6, a7,
    input  logic b0, b1, b2, b3, b4, b5, b6, b7,
    input  logic cin,
    output logic s0, s1, s2, s3, s4, s5, s6, s7,
    output logic cout
);

    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic [8:0] c;

    assign a    = {a7, a6, a5, a4, a3, a2, a1, a0};
    assign b    = {b7, b6, b5, b4, b3, b2, b1, b0};
    assign c[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign {s7, s6, s5, s4, s3, s2, s1, s0} = s;
    assign cout = c[8];

endmodule

// File: rtl/mult_8_bits_sequential.sv
// Sequential 8x8 unsigned shift-and-add multiplier; ZERO_BYPASS_EN short-circuits zero operands.
// Latency 9 cycles START->DONE (1 with bypass on a zero operand); one operation per 10 cycles.
// No backpressure: START is only sampled in IDLE and is dropped, not queued, while busy.
module mult_8_bits_sequential
    import mult_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [MULT_WIDTH-1:0] A,
    input  logic [MULT_WIDTH-1:0] B,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [PROD_WIDTH-1:0] PRODUCT
);

    state_t                  state_q, state_d;
    logic [MULT_WIDTH-1:0]   m_q, m_d;
    logic [MULT_WIDTH-1:0]   acc_q, acc_d;
    logic [MULT_WIDTH-1:0]   q_q, q_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [PROD_WIDTH-1:0]   product_q, product_d;

    logic [MULT_WIDTH-1:0]   add_b;
    logic [MULT_WIDTH-1:0]   add_sum;
    logic                    add_cout;

    assign add_b = q_q[0] ? m_q : '0;

    full_adder_8_bits_structure u_adder (
        .a0(acc_q[0]), .a1(acc_q[1]), .a2(acc_q[2]), .a3(acc_q[3]),
        .a4(acc_q[4]), .a5(acc_q[5]), .a6(acc_q[6]), .a7(acc_q[7]),
        .b0(add_b[0]), .b1(add_b[1]), .b2(add_b[2]), .b3(add_b[3]),
        .b4(add_b[4]), .b5(add_b[5]), .b6(add_b[6]), .b7(add_b[7]),
        .cin(1'b0),
        .s0(add_sum[0]), .s1(add_sum[1]), .s2(add_sum[2]), .s3(add_sum[3]),
        .s4(add_sum[4]), .s5(add_sum[5]), .s6(add_sum[6]), .s7(add_sum[7]),
        .cout(add_cout)
    );

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    m_d     = A;
                    q_d     = B;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
`ifdef ZERO_BYPASS_EN
                    if (A == '0 || B == '0) begin
                        state_d   = FINISH;
                        product_d = '0;
                    end
`endif
                end
            end
            CALC: begin
                // The carry-out lands in ACC[7] via the right shift, so the carry bit never needs storing.
                acc_d = {add_cout, add_sum[MULT_WIDTH-1:1]};
                q_d   = {add_sum[0], q_q[MULT_WIDTH-1:1]};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(ITER_LAST)) begin
                    state_d   = FINISH;
                    product_d = {acc_d, q_d};
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they line up with the state they describe.
        busy_d = (state_d == CALC);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign PRODUCT = product_q;

endmodule
